// File: rtl/cache_controller_if.sv
// cache_controller_if: CPU request/response and RAM read/write signals of the cache controller.
interface cache_controller_if;
    logic       cpu_req;
    logic       cpu_we;
    logic [5:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_done;
    logic       cpu_busy;
    logic [5:0] ram_readAddress;
    logic       ram_readEn;
    logic [7:0] ram_ReadData;
    logic [5:0] ram_writeAddress;
    logic [7:0] ram_writeData;
    logic       ram_writeEnable;
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_ReadData,
        output cpu_rdata, cpu_done, cpu_busy, ram_readAddress, ram_readEn,
               ram_writeAddress, ram_writeData, ram_writeEnable
    );
    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_ReadData,
        input  cpu_rdata, cpu_done, cpu_busy, ram_readAddress, ram_readEn,
               ram_writeAddress, ram_writeData, ram_writeEnable
    );
endinterface

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped, write-through, no-write-allocate byte cache in front of a 64x8 RAM.
// Define HIT_COUNTER_EN to add saturating read hit/miss counters.
module cache_controller #(
    parameter int LINES       = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic clk,
    input  logic Reset,
`ifdef HIT_COUNTER_EN
    output logic [15:0] hit_count,
    output logic [15:0] miss_count,
`endif
    cache_controller_if.master bus
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 6 - IW;
    localparam int CW = $clog2(MEM_LATENCY) + 1;
    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, RESP} state_t;
    state_t state, nextState;
    logic reqWe;
    logic [5:0] reqAddr;
    logic [7:0] reqWdata;
    logic [LINES-1:0] valid;
    logic [TW-1:0] tagArr [LINES];
    logic [7:0] dataArr [LINES];
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic hit, fillLast;
    assign idx = reqAddr[IW-1:0];
    assign tag = reqAddr[5:IW];
    assign hit = valid[idx] && tagArr[idx] == tag;
    assign fillLast = state == FILL && cnt == '0;
    always_ff @(posedge clk or negedge Reset)
        if (!Reset) state <= IDLE;
        else state <= nextState;
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = bus.cpu_req ? LOOKUP : IDLE;
            LOOKUP:  nextState = reqWe ? WRITE : hit ? RESP : FILL;
            FILL:    nextState = cnt == '0 ? RESP : FILL;
            WRITE:   nextState = RESP;
            default: nextState = IDLE;
        endcase
    end
    // Outputs are registered from nextState so each enable is high exactly while in its state
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            reqWe                <= 1'b0;
            reqAddr              <= '0;
            reqWdata             <= '0;
            valid                <= '0;
            cnt                  <= '0;
            bus.cpu_rdata        <= '0;
            bus.cpu_done         <= 1'b0;
            bus.cpu_busy         <= 1'b0;
            bus.ram_readAddress  <= '0;
            bus.ram_readEn       <= 1'b0;
            bus.ram_writeAddress <= '0;
            bus.ram_writeData    <= '0;
            bus.ram_writeEnable  <= 1'b0;
        end else begin
            if (state == IDLE && bus.cpu_req) begin
                reqWe    <= bus.cpu_we;
                reqAddr  <= bus.cpu_addr;
                reqWdata <= bus.cpu_wdata;
            end
            cnt <= state == LOOKUP ? CW'(MEM_LATENCY - 1) : cnt - CW'(state == FILL && cnt != '0);
            if (fillLast) valid[idx] <= 1'b1;
            bus.cpu_rdata <= state == LOOKUP && !reqWe && hit ? dataArr[idx] :
                             fillLast ? bus.ram_ReadData : bus.cpu_rdata;
            bus.cpu_done         <= state == RESP;
            bus.cpu_busy         <= nextState != IDLE;
            bus.ram_readEn       <= nextState == FILL;
            bus.ram_readAddress  <= nextState == FILL ? reqAddr : '0;
            bus.ram_writeEnable  <= nextState == WRITE;
            bus.ram_writeAddress <= nextState == WRITE ? reqAddr : '0;
            bus.ram_writeData    <= nextState == WRITE ? reqWdata : '0;
        end
    end
    always_ff @(posedge clk)
        if (fillLast) begin
            tagArr[idx]  <= tag;
            dataArr[idx] <= bus.ram_ReadData;
        end else if (state == WRITE && hit) dataArr[idx] <= reqWdata;
`ifdef HIT_COUNTER_EN
    always_ff @(posedge clk or negedge Reset)
        if (!Reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP && !reqWe) begin
            hit_count  <= hit_count + 16'(hit && hit_count != 16'hFFFF);
            miss_count <= miss_count + 16'(!hit && miss_count != 16'hFFFF);
        end
`endif
endmodule
